// File: rtl/petra_tx_queue.sv
// petra_tx_queue: host-side transmit queue feeding the petra core.
// Buffers host messages in a circular buffer and hands them to petra one at
// a time, waiting for an irq_tx rising edge (or a watchdog expiry) between
// messages.

`ifndef MESSAGE_SIZE
`define MESSAGE_SIZE 8
`endif

module petra_tx_queue #(
  parameter int unsigned MESSAGE_SIZE = `MESSAGE_SIZE,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned TIMEOUT      = 65535
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic [MESSAGE_SIZE-1:0] push_data,
  input  logic                    flush,
  output logic                    full,
  output logic                    empty,
  output logic [ADDR_W:0]         level,
  output logic                    overflow,
  output logic                    send_message,
  output logic [MESSAGE_SIZE-1:0] msg_data,
  input  logic                    irq_tx,
  output logic                    done,
  output logic                    tx_timeout,
  output logic [7:0]              sent_count,
  output logic [7:0]              drop_count
);

  // Watchdog only needs to count 0..TIMEOUT-1.
  localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t state, state_nx;

  logic [MESSAGE_SIZE-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]       wr_ptr;
  logic [ADDR_W-1:0]       rd_ptr;
  logic [WD_W-1:0]         wd;
  logic [WD_W-1:0]         wd_nx;
  logic                    irq_prev;

  logic                    irq_edge;
  logic                    wd_expired;
  logic                    do_push;
  logic                    do_pop;
  logic                    send_nx;
  logic                    done_nx;
  logic                    tmo_nx;
  logic [ADDR_W:0]         level_nx;
  logic                    overflow_nx;

  assign irq_edge   = irq_tx & ~irq_prev;
  assign wd_expired = (wd == WD_W'(TIMEOUT - 1));
  // A push while full is dropped even if a pop frees a slot the same cycle.
  assign do_push    = push & ~flush & ~full;
  // empty is registered, so an entry pushed this cycle waits for the next check.
  assign do_pop     = (state == ST_IDLE) & ~empty & ~flush;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state: launch when work is queued, return on completion or expiry
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (do_pop) state_nx = ST_WAIT;
        ST_WAIT: if (irq_edge || wd_expired) state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Output decode: next values of the registered handshake outputs and watchdog
  always_comb begin
    send_nx = 1'b0;
    done_nx = 1'b0;
    tmo_nx  = 1'b0;
    wd_nx   = wd;
    if (flush) begin
      wd_nx = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (do_pop) begin
            send_nx = 1'b1;
            wd_nx   = '0;
          end
        end
        ST_WAIT: begin
          wd_nx = wd + WD_W'(1);
          // Completion takes priority over a coincident expiry.
          if (irq_edge)        done_nx = 1'b1;
          else if (wd_expired) tmo_nx  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Occupancy and sticky overflow bookkeeping
  always_comb begin
    level_nx    = level + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
    overflow_nx = overflow | (push & full & ~flush);
    if (flush) begin
      level_nx    = '0;
      overflow_nx = 1'b0;
    end
  end

  // Payload storage; contents need no reset since pointers gate every read
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers, flags, watchdog, edge history and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      overflow     <= 1'b0;
      wd           <= '0;
      irq_prev     <= 1'b0;
      send_message <= 1'b0;
      msg_data     <= '0;
      done         <= 1'b0;
      tx_timeout   <= 1'b0;
      sent_count   <= '0;
      drop_count   <= '0;
    end else begin
      irq_prev     <= irq_tx;
      wd           <= wd_nx;
      send_message <= send_nx;
      done         <= done_nx;
      tx_timeout   <= tmo_nx;
      level        <= level_nx;
      full         <= (level_nx == (ADDR_W+1)'(DEPTH));
      empty        <= (level_nx == '0);
      overflow     <= overflow_nx;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (do_pop) begin
          rd_ptr   <= rd_ptr + ADDR_W'(1);
          msg_data <= mem[rd_ptr];
        end
      end
      if (done_nx) sent_count <= sent_count + 8'd1;
      if (tmo_nx)  drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_petra_tx_queue.sv
// Testbench for petra_tx_queue: scoreboard of payloads checked at every
// send_message, plus per-scenario checks of flags, counters and timing.

module tb_petra_tx_queue;

  localparam int unsigned TMO = 16;

  logic       clock;
  logic       reset;
  logic       push;
  logic [7:0] push_data;
  logic       flush;
  logic       full;
  logic       empty;
  logic [3:0] level;
  logic       overflow;
  logic       send_message;
  logic [7:0] msg_data;
  logic       irq_tx;
  logic       done;
  logic       tx_timeout;
  logic [7:0] sent_count;
  logic [7:0] drop_count;

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  int tmo_seen = 0;
  int exp_sent = 0;
  int exp_drop = 0;
  logic [7:0] sb [$];
  logic prev_send = 1'b0;

  petra_tx_queue #(
    .MESSAGE_SIZE(8),
    .DEPTH(8),
    .ADDR_W(3),
    .TIMEOUT(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .push(push),
    .push_data(push_data),
    .flush(flush),
    .full(full),
    .empty(empty),
    .level(level),
    .overflow(overflow),
    .send_message(send_message),
    .msg_data(msg_data),
    .irq_tx(irq_tx),
    .done(done),
    .tx_timeout(tx_timeout),
    .sent_count(sent_count),
    .drop_count(drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: payload order, single-cycle send pulse, done/timeout tallies
  always @(negedge clock) begin
    if (!reset) begin
      if (send_message) begin
        n_cmp++;
        if (sb.size() == 0) begin
          $display("FAIL send_unexpected: msg_data=%02h with nothing expected", msg_data);
          n_bad++;
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          if (msg_data !== e) begin
            $display("FAIL send_payload: got %02h expected %02h", msg_data, e);
            n_bad++;
          end
        end
        if (prev_send) begin
          n_cmp++;
          n_bad++;
          $display("FAIL send_width: send_message high 2 cycles, expected 1");
        end
      end
      if (done === 1'b1)       done_seen++;
      if (tx_timeout === 1'b1) tmo_seen++;
      prev_send = send_message;
    end else begin
      prev_send = 1'b0;
    end
  end

  task automatic tick;
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset;
    logic [33:0] got;
    logic [33:0] exp;
    #1;
    got = {full, empty, level, overflow, send_message, msg_data, done, tx_timeout, sent_count, drop_count};
    exp = {1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'd0};
    n_cmp++;
    if (got !== exp) begin
      $display("FAIL reset_values: got %09h expected %09h", got, exp);
      n_bad++;
    end
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_single;
    int d0;
    d0 = done_seen;
    push = 1'b1; push_data = 8'hA5; sb.push_back(8'hA5);
    tick;                                   // edge N
    push = 1'b0;
    n_cmp++;
    if (level !== 4'd1 || empty !== 1'b0) begin
      $display("FAIL single_enq: level=%0d empty=%0b expected level=1 empty=0", level, empty);
      n_bad++;
    end
    tick;                                   // edge N+1
    n_cmp++;
    if (send_message !== 1'b1 || msg_data !== 8'hA5 || level !== 4'd0) begin
      $display("FAIL single_send: send=%0b data=%02h level=%0d expected 1 a5 0", send_message, msg_data, level);
      n_bad++;
    end
    tick;                                   // edge N+2
    n_cmp++;
    if (send_message !== 1'b0 || msg_data !== 8'hA5) begin
      $display("FAIL single_fall: send=%0b data=%02h expected 0 a5", send_message, msg_data);
      n_bad++;
    end
    irq_tx = 1'b1;
    tick;                                   // edge M
    exp_sent++;
    n_cmp++;
    if (done !== 1'b1 || sent_count !== 8'(exp_sent)) begin
      $display("FAIL single_done: done=%0b sent=%0d expected 1 %0d", done, sent_count, exp_sent);
      n_bad++;
    end
    irq_tx = 1'b0;
    tick;
    n_cmp++;
    if (done !== 1'b0 || done_seen != d0 + 1) begin
      $display("FAIL single_done_pulse: done=%0b pulses=%0d expected 0 1", done, done_seen - d0);
      n_bad++;
    end
  endtask

  task automatic test_back_to_back;
    int d0;
    int t0;
    d0 = done_seen;
    t0 = tmo_seen;
    for (int i = 1; i <= 10; i++) begin
      push = 1'b1;
      push_data = 8'(i);
      if (i <= 9) sb.push_back(8'(i));
      tick;
      if (i == 9) begin
        n_cmp++;
        if (level !== 4'd8 || full !== 1'b1 || overflow !== 1'b0) begin
          $display("FAIL fill_full: level=%0d full=%0b ovf=%0b expected 8 1 0", level, full, overflow);
          n_bad++;
        end
      end
      if (i == 10) begin
        n_cmp++;
        if (level !== 4'd8 || overflow !== 1'b1) begin
          $display("FAIL fill_overflow: level=%0d ovf=%0b expected 8 1", level, overflow);
          n_bad++;
        end
      end
    end
    push = 1'b0;
    for (int k = 0; k < 9; k++) begin
      irq_tx = 1'b1; tick;
      irq_tx = 1'b0; tick;
      tick;
    end
    exp_sent += 9;
    n_cmp++;
    if (sb.size() != 0 || done_seen != d0 + 9 || tmo_seen != t0) begin
      $display("FAIL drain: left=%0d dones=%0d tmos=%0d expected 0 9 0", sb.size(), done_seen - d0, tmo_seen - t0);
      n_bad++;
    end
    n_cmp++;
    if (sent_count !== 8'(exp_sent) || empty !== 1'b1 || overflow !== 1'b1) begin
      $display("FAIL drain_state: sent=%0d empty=%0b ovf=%0b expected %0d 1 1", sent_count, empty, overflow, exp_sent);
      n_bad++;
    end
  endtask

  task automatic test_timeout;
    int d0;
    int s_at;
    int t_at;
    irq_tx = 1'b1;
    tick;
    push = 1'b1; push_data = 8'h11; sb.push_back(8'h11); tick;
    push_data = 8'h22; sb.push_back(8'h22); tick;
    push = 1'b0;
    tick; tick;
    d0 = done_seen;
    n_cmp++;
    if (done_seen != d0 || done !== 1'b0) begin
      $display("FAIL held_irq: done=%0b expected 0", done);
      n_bad++;
    end
    irq_tx = 1'b0; tick;
    irq_tx = 1'b1; tick;
    exp_sent++;
    n_cmp++;
    if (done !== 1'b1 || sent_count !== 8'(exp_sent)) begin
      $display("FAIL held_edge_done: done=%0b sent=%0d expected 1 %0d", done, sent_count, exp_sent);
      n_bad++;
    end
    d0 = done_seen;
    s_at = -1;
    t_at = -1;
    for (int i = 1; i <= 40 && t_at < 0; i++) begin
      tick;
      if (send_message === 1'b1) s_at = i;
      if (tx_timeout === 1'b1) t_at = i;
    end
    exp_drop++;
    n_cmp++;
    if (s_at < 0 || t_at < 0 || (t_at - s_at) != int'(TMO)) begin
      $display("FAIL timeout_delay: send@%0d timeout@%0d expected spacing %0d", s_at, t_at, TMO);
      n_bad++;
    end
    n_cmp++;
    if (drop_count !== 8'(exp_drop) || sent_count !== 8'(exp_sent) || done_seen != d0) begin
      $display("FAIL timeout_counts: drop=%0d sent=%0d expected %0d %0d", drop_count, sent_count, exp_drop, exp_sent);
      n_bad++;
    end
    tick;
    n_cmp++;
    if (tx_timeout !== 1'b0) begin
      $display("FAIL timeout_pulse: tx_timeout=%0b expected 0", tx_timeout);
      n_bad++;
    end
  endtask

  task automatic test_race;
    int t0;
    irq_tx = 1'b0;
    push = 1'b1; push_data = 8'h33; sb.push_back(8'h33);
    tick;
    push = 1'b0;
    tick;                                   // edge S
    n_cmp++;
    if (send_message !== 1'b1) begin
      $display("FAIL race_send: send=%0b expected 1", send_message);
      n_bad++;
    end
    t0 = tmo_seen;
    for (int i = 1; i < int'(TMO); i++) tick;
    irq_tx = 1'b1;
    tick;                                   // edge S+TMO
    exp_sent++;
    n_cmp++;
    if (done !== 1'b1 || tx_timeout !== 1'b0 || sent_count !== 8'(exp_sent) || drop_count !== 8'(exp_drop)) begin
      $display("FAIL race_priority: done=%0b tmo=%0b sent=%0d drop=%0d expected 1 0 %0d %0d",
               done, tx_timeout, sent_count, drop_count, exp_sent, exp_drop);
      n_bad++;
    end
    irq_tx = 1'b0;
    tick; tick;
    n_cmp++;
    if (tmo_seen != t0) begin
      $display("FAIL race_no_timeout: timeouts=%0d expected 0", tmo_seen - t0);
      n_bad++;
    end
  endtask

  task automatic test_flush;
    int d0;
    int t0;
    for (int i = 1; i <= 5; i++) begin
      push = 1'b1; push_data = 8'h40 + 8'(i); sb.push_back(8'h40 + 8'(i));
      tick;
    end
    push = 1'b1; push_data = 8'h77;
    flush = 1'b1;
    d0 = done_seen;
    t0 = tmo_seen;
    tick;
    flush = 1'b0;
    push = 1'b0;
    sb.delete();
    n_cmp++;
    if (level !== 4'd0 || empty !== 1'b1 || overflow !== 1'b0 || send_message !== 1'b0 || full !== 1'b0) begin
      $display("FAIL flush_state: level=%0d empty=%0b ovf=%0b send=%0b expected 0 1 0 0",
               level, empty, overflow, send_message);
      n_bad++;
    end
    for (int i = 0; i < 24; i++) tick;
    n_cmp++;
    if (done_seen != d0 || tmo_seen != t0 || sent_count !== 8'(exp_sent) || drop_count !== 8'(exp_drop)) begin
      $display("FAIL flush_quiet: dones=%0d tmos=%0d sent=%0d drop=%0d expected 0 0 %0d %0d",
               done_seen - d0, tmo_seen - t0, sent_count, drop_count, exp_sent, exp_drop);
      n_bad++;
    end
    push = 1'b1; push_data = 8'h5A; sb.push_back(8'h5A);
    tick;
    push = 1'b0;
    tick;
    n_cmp++;
    if (send_message !== 1'b1 || msg_data !== 8'h5A) begin
      $display("FAIL flush_resume: send=%0b data=%02h expected 1 5a", send_message, msg_data);
      n_bad++;
    end
    tick;
    irq_tx = 1'b1; tick;
    exp_sent++;
    irq_tx = 1'b0; tick;
    n_cmp++;
    if (sent_count !== 8'(exp_sent) || sb.size() != 0) begin
      $display("FAIL flush_resume_done: sent=%0d left=%0d expected %0d 0", sent_count, sb.size(), exp_sent);
      n_bad++;
    end
  endtask

  task automatic test_async_reset;
    int t0;
    logic [33:0] got;
    logic [33:0] exp;
    push = 1'b1; push_data = 8'hC3; sb.push_back(8'hC3);
    tick;
    push = 1'b1; push_data = 8'hC4;
    tick;
    push = 1'b0;
    tick; tick;
    t0 = tmo_seen;
    #2;
    reset = 1'b1;
    #1;
    got = {full, empty, level, overflow, send_message, msg_data, done, tx_timeout, sent_count, drop_count};
    exp = {1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'd0};
    n_cmp++;
    if (got !== exp) begin
      $display("FAIL async_reset: got %09h expected %09h", got, exp);
      n_bad++;
    end
    sb.delete();
    tick; tick;
    reset = 1'b0;
    tick; tick;
    n_cmp++;
    if (tx_timeout !== 1'b0 || tmo_seen != t0 || send_message !== 1'b0 || empty !== 1'b1) begin
      $display("FAIL reset_quiet: tmo=%0b send=%0b empty=%0b expected 0 0 1", tx_timeout, send_message, empty);
      n_bad++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    push = 1'b0;
    push_data = '0;
    flush = 1'b0;
    irq_tx = 1'b0;
    test_reset;
    test_single;
    test_back_to_back;
    test_timeout;
    test_race;
    test_flush;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
